// File: rtl/maze_game_ctrl.sv
// maze_game_ctrl: menu / map-preview / play controller for a hidden-wall maze.
// Each move reads one map ROM row and tests the target bit before committing.
module maze_game_ctrl #(
  parameter int MAP_W = 30,
  parameter int MAP_H = 21,
  parameter int SHOW_EASY = 100_000_000,
  parameter int SHOW_MED = 50_000_000,
  parameter int SHOW_HARD = 25_000_000,
  localparam int XW = $clog2(MAP_W),
  localparam int YW = $clog2(MAP_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       btn,
  input  logic             btn_sel,
  output logic [YW-1:0]    map_addr,
  input  logic [MAP_W-1:0] map_row,
  output logic [XW-1:0]    player_x,
  output logic [YW-1:0]    player_y,
  output logic [2:0]       state,
  output logic [1:0]       difficulty,
  output logic             map_visible,
  output logic             lost,
  output logic             won
);

  typedef enum logic [2:0] {
    MENU = 3'd0,
    SHOW = 3'd1,
    PLAY = 3'd2,
    LOST = 3'd3,
    WON  = 3'd4
  } st_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CHECK
  } mv_t;

  localparam logic [XW-1:0] LAST_X = XW'(MAP_W - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(MAP_H - 1);

  st_t st;
  mv_t mv;
  logic [31:0]   timer;
  logic [31:0]   show_len;
  logic [XW-1:0] tx, nx;
  logic [YW-1:0] ty, ny;
  logic          nok;

  assign state = st;

  always_comb begin
    show_len = 32'(SHOW_EASY);
    if (difficulty == 2'd1) show_len = 32'(SHOW_MED);
    if (difficulty == 2'd2) show_len = 32'(SHOW_HARD);
  end

  // Target cell with up > down > left > right priority and edge clipping
  always_comb begin
    nx = player_x;
    ny = player_y;
    nok = 1'b0;
    if (btn[0]) begin
      ny = player_y - YW'(1);
      nok = (player_y != '0);
    end else if (btn[1]) begin
      ny = player_y + YW'(1);
      nok = (player_y != LAST_Y);
    end else if (btn[2]) begin
      nx = player_x - XW'(1);
      nok = (player_x != '0);
    end else if (btn[3]) begin
      nx = player_x + XW'(1);
      nok = (player_x != LAST_X);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= MENU;
      mv <= IDLE;
      difficulty <= 2'd0;
      player_x <= '0;
      player_y <= LAST_Y;
      map_addr <= LAST_Y;
      timer <= '0;
      tx <= '0;
      ty <= '0;
      map_visible <= 1'b0;
      lost <= 1'b0;
      won <= 1'b0;
    end else begin
      unique case (st)
        MENU: begin
          if (btn_sel) begin
            timer <= show_len;
            map_visible <= 1'b1;
            st <= SHOW;
          end else if (btn[2]) begin
            difficulty <= (difficulty == 2'd0) ? 2'd2
                        : difficulty - 2'd1;
          end else if (btn[3]) begin
            difficulty <= (difficulty == 2'd2) ? 2'd0
                        : difficulty + 2'd1;
          end
        end
        SHOW: begin
          if (btn_sel || timer == 32'd1) begin
            timer <= '0;
            map_visible <= 1'b0;
            st <= btn_sel ? MENU : PLAY;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        PLAY: begin
          unique case (mv)
            IDLE: begin
              if (nok) begin
                tx <= nx;
                ty <= ny;
                map_addr <= ny;
                mv <= FETCH;
              end
            end
            FETCH: begin
              map_addr <= player_y;
              mv <= CHECK;
            end
            CHECK: begin
              mv <= IDLE;
              if (map_row[tx]) begin
                lost <= 1'b1;
                st <= LOST;
              end else begin
                player_x <= tx;
                player_y <= ty;
                map_addr <= ty;
                if (tx == LAST_X && ty == '0) begin
                  won <= 1'b1;
                  st <= WON;
                end
              end
            end
            default: mv <= IDLE;
          endcase
        end
        LOST, WON: begin
          if (btn_sel) begin
            st <= MENU;
            lost <= 1'b0;
            won <= 1'b0;
            player_x <= '0;
            player_y <= LAST_Y;
            map_addr <= LAST_Y;
          end
        end
        default: st <= MENU;
      endcase
    end
  end

endmodule
